// File: rtl/opl3_wq_pkg.sv
// -----------------------------------------------------------------------------
// opl3_wq_pkg
// Shared types and constants for the OPL3 write queue.
//   opl3_wq_entry_t : one captured CPU write, {addr[1:0], data[7:0]}
//   opl3_wq_state_t : replay FSM states (IDLE, STROBE, GAP)
//   ENTRY_W         : width of one queue entry in bits
// -----------------------------------------------------------------------------
package opl3_wq_pkg;

  localparam int ENTRY_W = 10;

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
  } opl3_wq_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    GAP    = 2'd2
  } opl3_wq_state_t;

endpackage

// File: rtl/opl3_wq_fifo.sv
// -----------------------------------------------------------------------------
// opl3_wq_fifo
// Synchronous FIFO holding captured CPU writes for replay.
//   clk, rst_n  : clock, synchronous active-low reset (empties the FIFO)
//   push        : write push_entry at this edge (ignored when full)
//   push_entry  : entry to store
//   pop         : discard the head at this edge (ignored when empty)
//   head        : oldest stored entry, read from the storage registers
//   full, empty : count == DEPTH / count == 0
//   count       : number of stored entries, 0..DEPTH
//
// Push/pop contract: push and pop are single-cycle requests acting at the
// rising edge where they are high. A push is accepted only when full=0 and a
// pop only when empty=0; both may act at the same edge, leaving count
// unchanged. head is valid whenever empty=0.
// DEPTH must be a power of two (>= 2) so pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module opl3_wq_fifo
  import opl3_wq_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  opl3_wq_entry_t push_entry,
  input  logic           pop,
  output opl3_wq_entry_t head,
  output logic           full,
  output logic           empty,
  output logic [CNT_W-1:0] count
);

  opl3_wq_entry_t   mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/opl3_write_queue.sv
// -----------------------------------------------------------------------------
// opl3_write_queue
// Captures CPU writes to the four OPL3 ports into a FIFO and replays them to
// the core as clean write strobes, paced by a gap counted in ce_1us ticks.
//   clk, rst_n         : clock, synchronous active-low reset
//   ce_1us             : one-cycle pulse per microsecond
//   cpu_addr, cpu_din  : CPU port address / write data
//   cpu_we             : CPU write level; a write is its rising edge
//   opl_addr, opl_din  : address / data presented to the core
//   opl_we             : write strobe, high for WE_HOLD cycles per write
//   full               : FIFO holds DEPTH entries (new writes are dropped)
//   busy               : FIFO not empty or replay FSM not IDLE
//   drop_cnt           : saturating count of dropped writes
//   dbg_state          : current replay FSM state
// Optional feature: define OPL3_WQ_DROP_CNT_EN to build the drop counter;
// otherwise drop_cnt is tied to zero.
// -----------------------------------------------------------------------------
module opl3_write_queue
  import opl3_wq_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_GAP_US = 3,
  parameter int DATA_GAP_US = 3,
  parameter int WE_HOLD     = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce_1us,
  input  logic [1:0]     cpu_addr,
  input  logic [7:0]     cpu_din,
  input  logic           cpu_we,
  output logic [1:0]     opl_addr,
  output logic [7:0]     opl_din,
  output logic           opl_we,
  output logic           full,
  output logic           busy,
  output logic [7:0]     drop_cnt,
  output opl3_wq_state_t dbg_state
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int GAP_MAX = (ADDR_GAP_US > DATA_GAP_US) ? ADDR_GAP_US : DATA_GAP_US;
  localparam int GAP_W   = (GAP_MAX < 2) ? 1 : $clog2(GAP_MAX + 1);
  localparam int HOLD_W  = (WE_HOLD < 2) ? 1 : $clog2(WE_HOLD + 1);

  opl3_wq_state_t    state_q, state_d;
  logic              cpu_we_q, cpu_we_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [1:0]        opl_addr_q, opl_addr_d;
  logic [7:0]        opl_din_q, opl_din_d;
  logic              opl_we_q, opl_we_d;

  logic              write_edge;
  logic              fifo_pop;
  logic              launch;
  opl3_wq_entry_t    push_entry;
  opl3_wq_entry_t    head_entry;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  assign write_edge = cpu_we & ~cpu_we_q;
  assign push_entry = '{addr: cpu_addr, data: cpu_din};

  opl3_wq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (write_edge),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head       (head_entry),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // Replay FSM. A new write is launched from IDLE, or straight out of GAP once
  // the gap has expired, so a zero gap costs exactly one low cycle of opl_we.
  always_comb begin
    state_d    = state_q;
    cpu_we_d   = cpu_we;
    hold_d     = hold_q;
    gap_d      = gap_q;
    opl_addr_d = opl_addr_q;
    opl_din_d  = opl_din_q;
    opl_we_d   = opl_we_q;
    launch     = 1'b0;
    fifo_pop   = 1'b0;

    case (state_q)
      IDLE: begin
        launch = ~fifo_empty;
      end
      STROBE: begin
        if (hold_q <= HOLD_W'(1)) begin
          opl_we_d = 1'b0;
          // opl_addr_q still holds the write just strobed.
          gap_d    = opl_addr_q[0] ? GAP_W'(DATA_GAP_US) : GAP_W'(ADDR_GAP_US);
          state_d  = GAP;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
          launch  = ~fifo_empty;
        end else if (ce_1us) begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        opl_we_d = 1'b0;
      end
    endcase

    if (launch) begin
      fifo_pop   = 1'b1;
      opl_addr_d = head_entry.addr;
      opl_din_d  = head_entry.data;
      opl_we_d   = 1'b1;
      hold_d     = HOLD_W'(WE_HOLD);
      state_d    = STROBE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cpu_we_q   <= 1'b0;
      hold_q     <= '0;
      gap_q      <= '0;
      opl_addr_q <= '0;
      opl_din_q  <= '0;
      opl_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpu_we_q   <= cpu_we_d;
      hold_q     <= hold_d;
      gap_q      <= gap_d;
      opl_addr_q <= opl_addr_d;
      opl_din_q  <= opl_din_d;
      opl_we_q   <= opl_we_d;
    end
  end

`ifdef OPL3_WQ_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // A write arriving while full is lost even if a pop happens at that edge.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (write_edge && fifo_full && (drop_cnt_q != 8'hFF))
      drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

  assign opl_addr  = opl_addr_q;
  assign opl_din   = opl_din_q;
  assign opl_we    = opl_we_q;
  assign full      = fifo_full;
  assign busy      = (fifo_count != '0) | (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_opl3_write_queue.sv
// -----------------------------------------------------------------------------
// tb_opl3_write_queue
// Directed bench for opl3_write_queue. The main instance uses the default
// parameters; a second instance with zero gaps and WE_HOLD=1 shares its inputs.
// Writes expected to be replayed are pushed to exp_q; a negedge monitor pops
// and compares on every rising edge of opl_we and checks strobe width and gap.
// -----------------------------------------------------------------------------
module tb_opl3_write_queue;
  import opl3_wq_pkg::*;

  localparam int ADDR_GAP = 3;
  localparam int DATA_GAP = 3;
  localparam int HOLD     = 2;

  // ---------------- clock / reset / inputs ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce_1us = 1'b0;
  logic [1:0] cpu_addr = '0;
  logic [7:0] cpu_din = '0;
  logic       cpu_we = 1'b0;

  always #5 clk = ~clk;

  logic [1:0]     opl_addr, f_opl_addr;
  logic [7:0]     opl_din, f_opl_din;
  logic           opl_we, f_opl_we;
  logic           full, f_full;
  logic           busy, f_busy;
  logic [7:0]     drop_cnt, f_drop_cnt;
  opl3_wq_state_t dbg_state, f_dbg_state;

  opl3_write_queue #(.DEPTH(16), .ADDR_GAP_US(ADDR_GAP), .DATA_GAP_US(DATA_GAP),
                     .WE_HOLD(HOLD)) u_dut (
    .clk(clk), .rst_n(rst_n), .ce_1us(ce_1us), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_we(cpu_we), .opl_addr(opl_addr), .opl_din(opl_din),
    .opl_we(opl_we), .full(full), .busy(busy), .drop_cnt(drop_cnt),
    .dbg_state(dbg_state)
  );

  opl3_write_queue #(.DEPTH(16), .ADDR_GAP_US(0), .DATA_GAP_US(0),
                     .WE_HOLD(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .ce_1us(ce_1us), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_we(cpu_we), .opl_addr(f_opl_addr), .opl_din(f_opl_din),
    .opl_we(f_opl_we), .full(f_full), .busy(f_busy), .drop_cnt(f_drop_cnt),
    .dbg_state(f_dbg_state)
  );

`ifdef OPL3_WQ_DROP_CNT_EN
  localparam logic [7:0] EXP_DROP = 8'd1;
`else
  localparam logic [7:0] EXP_DROP = 8'd0;
`endif

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass = 0;
  logic [9:0]  exp_q[$];
  bit          ce_run = 1'b0;
  int unsigned div = 0;
  bit          mon_reset = 1'b1;
  int          n_strobes = 0;
  int          strobes_before = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_ge(input string name, input int act, input int min);
    n_checks++;
    if (act >= min) n_pass++;
    else $display("FAIL %s: got %0d, expected at least %0d", name, act, min);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge and hold for that cycle.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (ce_run) begin
        ce_1us = (div == 0);
        div    = (div + 1) % 4;
      end
    end
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d, input bit accept);
    cpu_addr = a;
    cpu_din  = d;
    cpu_we   = 1'b1;
    if (accept) exp_q.push_back({a, d});
    step(1);
    cpu_we = 1'b0;
    step(1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i;
    i = 0;
    while (busy && i < budget) begin
      step(1);
      i++;
    end
    check(name, busy, 0);
  endtask

  // ---------------- monitor ----------------
  logic       we_prev = 1'b0;
  bit         have_prev = 1'b0;
  int         width = 0;
  int         ticks = 0;
  int         need = 0;
  logic [9:0] exp_e;

  always @(negedge clk) begin
    if (mon_reset) begin
      we_prev   = 1'b0;
      have_prev = 1'b0;
      width     = 0;
      ticks     = 0;
    end else begin
      if (opl_we && !we_prev) begin
        n_strobes++;
        check_ge("strobe_expected", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          exp_e = exp_q.pop_front();
          check("replay_entry", {22'd0, opl_addr, opl_din}, {22'd0, exp_e});
        end
        if (have_prev) check_ge("gap_ticks", ticks, need);
        width = 1;
      end else if (opl_we && we_prev) begin
        width++;
      end else if (!opl_we && we_prev) begin
        check("strobe_width", width, HOLD);
        have_prev = 1'b1;
        need      = opl_addr[0] ? DATA_GAP : ADDR_GAP;
        ticks     = 0;
      end
      if (!opl_we && have_prev && ce_1us) ticks++;
      we_prev = opl_we;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    rst_n = 1'b0;
    mon_reset = 1'b1;
    step(3);
    check("rst_opl_we", opl_we, 0);
    check("rst_opl_addr", opl_addr, 0);
    check("rst_opl_din", opl_din, 0);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_state", dbg_state, 32'(IDLE));
    rst_n = 1'b1;
    mon_reset = 1'b0;
    step(1);

    // Single data write: latency, strobe, busy after 3 ticks
    cpu_addr = 2'd1; cpu_din = 8'h5A; cpu_we = 1'b1;
    exp_q.push_back({2'd1, 8'h5A});
    step(1);
    cpu_we = 1'b0;
    check("t1_we_t1", opl_we, 0);
    step(1);
    check("t1_we_t2", opl_we, 1);
    check("t1_addr", opl_addr, 1);
    check("t1_din", opl_din, 8'h5A);
    check("t1_busy", busy, 1);
    step(1);
    check("t1_we_t3", opl_we, 1);
    step(1);
    check("t1_we_t4", opl_we, 0);
    step(5);
    check("t1_busy_no_tick", busy, 1);
    ce_1us = 1'b1;
    step(3);
    ce_1us = 1'b0;
    check("t1_busy_gap_end", busy, 1);
    step(1);
    check("t1_busy_done", busy, 0);

    // Burst of four writes, paced by ce_1us
    ce_run = 1'b1;
    div = 0;
    cpu_write(2'd0, 8'h20, 1'b1);
    cpu_write(2'd1, 8'h01, 1'b1);
    cpu_write(2'd0, 8'hA0, 1'b1);
    cpu_write(2'd1, 8'h44, 1'b1);
    wait_idle("t2_idle", 1000);

    // Fill with ce_1us held low: first write goes to strobe, 16 fill, next drops
    ce_run = 1'b0;
    ce_1us = 1'b0;
    for (int i = 0; i < 16; i++) cpu_write(2'(i % 4), 8'(8'h80 + i), 1'b1);
    check("t3_not_full_15", full, 0);
    cpu_write(2'd3, 8'h90, 1'b1);
    check("t3_full_16", full, 1);
    cpu_write(2'd2, 8'hEE, 1'b0);
    check("t3_full_after_drop", full, 1);
    check("t3_drop_cnt", drop_cnt, EXP_DROP);
    ce_run = 1'b1;
    wait_idle("t3_idle", 2000);
    check("t3_full_cleared", full, 0);
    check("t3_drop_cnt_kept", drop_cnt, EXP_DROP);

    // Push in the same cycle as a pop with five entries queued
    ce_run = 1'b0;
    ce_1us = 1'b0;
    cpu_write(2'd0, 8'h10, 1'b1);
    for (int i = 1; i <= 5; i++) cpu_write(2'd1, 8'(8'h10 + i), 1'b1);
    ce_1us = 1'b1;
    step(3);
    ce_1us = 1'b0;
    cpu_addr = 2'd0; cpu_din = 8'h16; cpu_we = 1'b1;
    exp_q.push_back({2'd0, 8'h16});
    step(1);
    cpu_we = 1'b0;
    check("t5_pop_strobe", opl_we, 1);
    check("t5_pop_din", opl_din, 8'h11);
    step(1);
    for (int i = 0; i < 10; i++) cpu_write(2'd3, 8'(8'h30 + i), 1'b1);
    check("t5_not_full_15", full, 0);
    cpu_write(2'd3, 8'h3A, 1'b1);
    check("t5_full_16", full, 1);
    ce_run = 1'b1;
    wait_idle("t5_idle", 2000);

    // Zero-gap instance: strobe pattern 1,0,1
    ce_run = 1'b0;
    ce_1us = 1'b0;
    step(2);
    cpu_addr = 2'd0; cpu_din = 8'h55; cpu_we = 1'b1;
    exp_q.push_back({2'd0, 8'h55});
    step(1);
    cpu_we = 1'b0;
    step(1);
    cpu_addr = 2'd1; cpu_din = 8'hAA; cpu_we = 1'b1;
    exp_q.push_back({2'd1, 8'hAA});
    check("t4_fast_we_0", f_opl_we, 1);
    check("t4_fast_addr_0", f_opl_addr, 0);
    check("t4_fast_din_0", f_opl_din, 8'h55);
    step(1);
    cpu_we = 1'b0;
    check("t4_fast_we_1", f_opl_we, 0);
    step(1);
    check("t4_fast_we_2", f_opl_we, 1);
    check("t4_fast_addr_2", f_opl_addr, 1);
    check("t4_fast_din_2", f_opl_din, 8'hAA);
    step(1);
    check("t4_fast_we_3", f_opl_we, 0);
    ce_run = 1'b1;
    wait_idle("t4_idle", 500);
    check("all_replayed", exp_q.size(), 0);

    // Reset during STROBE with three entries queued
    ce_run = 1'b0;
    ce_1us = 1'b0;
    for (int i = 0; i < 5; i++) cpu_write(2'(i), 8'(8'hC0 + i), 1'b1);
    ce_1us = 1'b1;
    step(3);
    ce_1us = 1'b0;
    step(1);
    check("t6_strobe_pre_rst", opl_we, 1);
    check("t6_din_pre_rst", opl_din, 8'hC1);
    rst_n = 1'b0;
    step(1);
    mon_reset = 1'b1;
    exp_q.delete();
    check("t6_rst_we", opl_we, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_full", full, 0);
    check("t6_rst_addr", opl_addr, 0);
    check("t6_rst_state", dbg_state, 32'(IDLE));
    step(2);
    rst_n = 1'b1;
    mon_reset = 1'b0;
    strobes_before = n_strobes;
    ce_run = 1'b1;
    step(200);
    check("t6_no_strobe_after", n_strobes, strobes_before);
    check("t6_busy_after", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
